apb_gpio_irq: RTL and testbench

Parametrised APB3 GPIO peripheral, successor to the fixed 8-bit GPIO. Adds per-pin direction control, synchronised inputs, edge-triggered interrupts with write-1-to-clear status, a configurable wait-state handshake and an error response. Sits on the APB peripheral bus and drives/samples DATA_W pins.

---
 rtl/apb_gpio_irq.sv | 155 +++++++++++++++
 tb/tb_apb_gpio_irq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO peripheral: per-pin direction, synchronised inputs, edge interrupts
// with write-1-to-clear status, programmable wait states and an error response.
module apb_gpio_irq #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [DATA_W-1:0] gpio_in,
    output logic [DATA_W-1:0] gpio_out,
    output logic [DATA_W-1:0] gpio_oe,
    output logic              irq
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(WAIT_STATES);

    localparam logic [2:0] IDX_DATA_OUT = 3'd0;
    localparam logic [2:0] IDX_DIR      = 3'd1;
    localparam logic [2:0] IDX_DATA_IN  = 3'd2;
    localparam logic [2:0] IDX_IRQ_EN   = 3'd3;
    localparam logic [2:0] IDX_IRQ_EDGE = 3'd4;
    localparam logic [2:0] IDX_IRQ_STAT = 3'd5;

    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-1:0] dir_q, dir_d;
    logic [DATA_W-1:0] irq_en_q, irq_en_d;
    logic [DATA_W-1:0] irq_edge_q, irq_edge_d;
    logic [DATA_W-1:0] irq_status_q, irq_status_d;
    logic [DATA_W-1:0] sync1_q, sync2_q, sync3_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              irq_q, irq_d;

    logic              access;
    logic              ready;
    logic              upper_zero;
    logic              mapped;
    logic              wr_commit;
    logic [2:0]        idx;
    logic [DATA_W-1:0] evt;
    logic [DATA_W-1:0] w1c_mask;
    logic [DATA_W-1:0] rd_mux;

    assign idx    = PADDR[2:0];
    assign access = PSEL & PENABLE;
    assign ready  = access & (cnt_q == WAIT_MAX);

    generate
        if (ADDR_W > 3) begin : g_upper
            assign upper_zero = ~|PADDR[ADDR_W-1:3];
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    assign mapped    = upper_zero & (idx <= IDX_IRQ_STAT);
    assign wr_commit = ready & PWRITE & mapped;

    // Edge detect on the synchronised pair; only input pins with IRQ_EN set can fire.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_evt
            logic rise, fall;
            assign rise    = sync2_q[gi] & ~sync3_q[gi];
            assign fall    = ~sync2_q[gi] & sync3_q[gi];
            assign evt[gi] = ~dir_q[gi] & irq_en_q[gi] & (irq_edge_q[gi] ? rise : fall);
        end
    endgenerate

    assign w1c_mask = (wr_commit && idx == IDX_IRQ_STAT) ? PWDATA : '0;

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        irq_edge_d = irq_edge_q;
        cnt_d      = '0;

        if (access) begin
            cnt_d = (cnt_q == WAIT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end

        if (wr_commit) begin
            case (idx)
                IDX_DATA_OUT: data_out_d = PWDATA;
                IDX_DIR:      dir_d      = PWDATA;
                IDX_IRQ_EN:   irq_en_d   = PWDATA;
                IDX_IRQ_EDGE: irq_edge_d = PWDATA;
                default:      ;
            endcase
        end

        // A set arriving in the same cycle as its W1C clear takes priority.
        irq_status_d = (irq_status_q & ~w1c_mask) | evt;
        irq_d        = |(irq_status_q & irq_en_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            irq_edge_q   <= '0;
            irq_status_q <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            cnt_q        <= '0;
            irq_q        <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            irq_en_q     <= irq_en_d;
            irq_edge_q   <= irq_edge_d;
            irq_status_q <= irq_status_d;
            sync1_q      <= gpio_in;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            cnt_q        <= cnt_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (mapped) begin
            case (idx)
                IDX_DATA_OUT: rd_mux = data_out_q;
                IDX_DIR:      rd_mux = dir_q;
                IDX_DATA_IN:  rd_mux = sync2_q;
                IDX_IRQ_EN:   rd_mux = irq_en_q;
                IDX_IRQ_EDGE: rd_mux = irq_edge_q;
                IDX_IRQ_STAT: rd_mux = irq_status_q;
                default:      rd_mux = '0;
            endcase
        end
    end

    assign PREADY   = ready;
    assign PRDATA   = ready ? rd_mux : '0;
    assign PSLVERR  = ready & ~mapped;
    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Directed bench for apb_gpio_irq (DATA_W=8, WAIT_STATES=2): register table
// followed by hand-written interrupt, abandon and reset sequences.
module tb_apb_gpio_irq;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int WS = 2;

    logic          PCLK;
    logic          PRESETn;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [DW-1:0] gpio_in;
    logic [DW-1:0] gpio_out;
    logic [DW-1:0] gpio_oe;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    apb_gpio_irq #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] gin;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        logic [DW-1:0] exp_out;
        logic [DW-1:0] exp_oe;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One complete transfer; optionally changes gpio_in as the access phase begins.
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic chg, input logic [DW-1:0] new_in,
                            output logic [DW-1:0] rdata, output logic err, output int waits);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        check("setup_pready_low", {31'd0, PREADY}, 32'd0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (chg) gpio_in = new_in;
        waits = 0;
        while (!PREADY && waits < 20) begin
            @(posedge PCLK); #1;
            waits++;
        end
        checks++;
        if (!PREADY) begin
            failures++;
            $display("FAIL pready_timeout actual=%0d expected=%0d", waits, WS);
        end
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        $display("xfer wr=%0d addr=0x%02h wdata=0x%02h rdata=0x%02h err=%0d waits=%0d",
                 wr, addr, wdata, rdata, err, waits);
    endtask

    task automatic apb_read_check(input string name, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] exp);
        logic [DW-1:0] rd;
        logic          er;
        int            w;
        apb_xfer(1'b0, addr, '0, 1'b0, '0, rd, er, w);
        check(name, {24'd0, rd}, {24'd0, exp});
    endtask

    task automatic apb_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic [DW-1:0] rd;
        logic          er;
        int            w;
        apb_xfer(1'b1, addr, data, 1'b0, '0, rd, er, w);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge PCLK); #1; end
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          er;
        int            w;
        int            n;

        //           wr    addr   wdata  gin    exp_rd exp_err out   oe
        vecs[0]  = '{1'b1, 8'h00, 8'hCC, 8'h00, 8'h00, 1'b0, 8'hCC, 8'h00};
        vecs[1]  = '{1'b1, 8'h01, 8'hF0, 8'h00, 8'h00, 1'b0, 8'hCC, 8'hF0};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'hCC, 1'b0, 8'hCC, 8'hF0};
        vecs[3]  = '{1'b0, 8'h01, 8'h00, 8'h00, 8'hF0, 1'b0, 8'hCC, 8'hF0};
        vecs[4]  = '{1'b1, 8'h02, 8'h12, 8'h5A, 8'h00, 1'b0, 8'hCC, 8'hF0};
        vecs[5]  = '{1'b0, 8'h02, 8'h00, 8'h5A, 8'h5A, 1'b0, 8'hCC, 8'hF0};
        vecs[6]  = '{1'b0, 8'h07, 8'h00, 8'h5A, 8'h00, 1'b1, 8'hCC, 8'hF0};
        vecs[7]  = '{1'b1, 8'h07, 8'hFF, 8'h5A, 8'h00, 1'b1, 8'hCC, 8'hF0};
        vecs[8]  = '{1'b0, 8'h40, 8'h00, 8'h5A, 8'h00, 1'b1, 8'hCC, 8'hF0};
        vecs[9]  = '{1'b1, 8'h08, 8'h77, 8'h5A, 8'h00, 1'b1, 8'hCC, 8'hF0};
        vecs[10] = '{1'b1, 8'h03, 8'h01, 8'h5A, 8'h00, 1'b0, 8'hCC, 8'hF0};
        vecs[11] = '{1'b1, 8'h04, 8'h01, 8'h5A, 8'h00, 1'b0, 8'hCC, 8'hF0};
        vecs[12] = '{1'b0, 8'h03, 8'h00, 8'h5A, 8'h01, 1'b0, 8'hCC, 8'hF0};
        vecs[13] = '{1'b0, 8'h04, 8'h00, 8'h5A, 8'h01, 1'b0, 8'hCC, 8'hF0};

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; gpio_in = '0;
        idle(3);
        check("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        check("rst_gpio_oe",  {24'd0, gpio_oe},  32'd0);
        check("rst_irq",      {31'd0, irq},      32'd0);
        check("rst_pready",   {31'd0, PREADY},   32'd0);
        PRESETn = 1'b1;
        idle(1);

        for (int i = 0; i < 14; i++) begin
            gpio_in = vecs[i].gin;
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, '0, rd, er, w);
            check($sformatf("vec%0d_waits", i), w, WS);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            if (!vecs[i].wr)
                check($sformatf("vec%0d_rdata", i), {24'd0, rd}, {24'd0, vecs[i].exp_rd});
            check($sformatf("vec%0d_gpio_out", i), {24'd0, gpio_out}, {24'd0, vecs[i].exp_out});
            check($sformatf("vec%0d_gpio_oe", i), {24'd0, gpio_oe}, {24'd0, vecs[i].exp_oe});
        end

        // Rising edge on an input pin with IRQ enabled.
        apb_write(8'h01, 8'h00);
        check("irq_idle_low", {31'd0, irq}, 32'd0);
        gpio_in = 8'h5B;
        n = 0;
        while (!irq && n < 8) begin
            @(posedge PCLK); #1;
            n++;
        end
        check("irq_rise_cycles", n, 4);
        apb_read_check("status_after_rise", 8'h05, 8'h01);
        apb_read_check("data_in_after_rise", 8'h02, 8'h5B);

        // W1C clears status; irq follows one cycle later.
        apb_write(8'h05, 8'h01);
        idle(1);
        check("irq_low_after_w1c", {31'd0, irq}, 32'd0);
        apb_read_check("status_after_w1c", 8'h05, 8'h00);

        // Falling edge on bit 0 and any edge on disabled bit 1 must not set status.
        gpio_in = 8'h5A; idle(5);
        apb_read_check("status_after_fall", 8'h05, 8'h00);
        gpio_in = 8'h58; idle(5);
        gpio_in = 8'h5A; idle(5);
        apb_read_check("status_after_bit1", 8'h05, 8'h00);

        // Output pins do not raise events even when enabled.
        apb_write(8'h01, 8'h01);
        gpio_in = 8'h5B; idle(5);
        apb_read_check("status_output_pin", 8'h05, 8'h00);
        gpio_in = 8'h5A; idle(5);
        apb_write(8'h01, 8'h00);

        // IRQ_EN masks irq without clearing status.
        gpio_in = 8'h5B; idle(5);
        check("irq_before_mask", {31'd0, irq}, 32'd1);
        apb_write(8'h03, 8'h00);
        idle(1);
        check("irq_masked", {31'd0, irq}, 32'd0);
        apb_read_check("status_kept_masked", 8'h05, 8'h01);
        apb_write(8'h03, 8'h01);
        gpio_in = 8'h5A; idle(5);

        // Set and W1C clear on the same edge: set wins.
        apb_xfer(1'b1, 8'h05, 8'h01, 1'b1, 8'h5B, rd, er, w);
        apb_read_check("status_set_wins", 8'h05, 8'h01);
        idle(1);
        check("irq_set_wins", {31'd0, irq}, 32'd1);

        // Abandoned write during a wait state.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'hFF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        check("abandon_pready_low", {31'd0, PREADY}, 32'd0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        $display("xfer abandoned wr=1 addr=0x00 wdata=0xff");
        idle(3);
        check("abandon_gpio_out", {24'd0, gpio_out}, 32'h0000_00CC);
        apb_xfer(1'b0, 8'h00, '0, 1'b0, '0, rd, er, w);
        check("abandon_next_waits", w, WS);
        check("abandon_readback", {24'd0, rd}, 32'h0000_00CC);

        // Reset asserted in the middle of an access phase.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h01; PWDATA = 8'hAA;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        check("midrst_prdata",   {24'd0, PRDATA},   32'd0);
        check("midrst_pready",   {31'd0, PREADY},   32'd0);
        check("midrst_pslverr",  {31'd0, PSLVERR},  32'd0);
        check("midrst_gpio_out", {24'd0, gpio_out}, 32'd0);
        check("midrst_gpio_oe",  {24'd0, gpio_oe},  32'd0);
        check("midrst_irq",      {31'd0, irq},      32'd0);
        idle(2);
        PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        $display("xfer aborted by reset wr=1 addr=0x01 wdata=0xaa");
        apb_xfer(1'b0, 8'h01, '0, 1'b0, '0, rd, er, w);
        check("postrst_dir", {24'd0, rd}, 32'd0);
        check("postrst_err", {31'd0, er}, 32'd0);
        check("postrst_waits", w, WS);
        apb_read_check("postrst_data_out", 8'h00, 8'h00);
        apb_read_check("postrst_status", 8'h05, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
